// File: rtl/calc_seq_alu.sv
// -----------------------------------------------------------------------------
// calc_seq_alu -- multi-cycle calculator ALU with a start/done handshake.
//
// Two WIDTH-bit unsigned operands and a 3-bit opcode are captured when start
// is seen in IDLE. Logic/arithmetic ops finish in one cycle; MUL (shift-add)
// and DIV (restoring) iterate one bit per cycle for WIDTH cycles. Results and
// flags are registered and hold until the next operation completes.
//
// Optional feature macro: CALC_DIV_EN
//   defined   : restoring divider built, opcode 110 computes quotient/remainder
//   undefined : no divider logic; opcode 110 completes in one cycle with
//               lo=0, hi=0, err=1, zero=1
//
// Ports:
//   clk, rst_n          clock (rising edge) / async active-low reset
//   start, op, a, b     request, opcode and operands (sampled only in IDLE)
//   busy                high while the state is not IDLE
//   done                one-cycle pulse when results/flags update
//   result_lo/hi        result words (hi: MUL upper half, DIV remainder)
//   carry, ovf          ADD carry / SUB borrow, signed overflow (ADD/SUB)
//   zero, err           {hi,lo}==0, divide-by-zero or disabled opcode
// -----------------------------------------------------------------------------
module calc_seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             carry,
    output logic             ovf,
    output logic             zero,
    output logic             err
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_MUL = 3'b101,
        OP_DIV = 3'b110,
        OP_CMP = 3'b111
    } op_e;

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] b_q, b_d;
    // p_hi/p_lo: MUL partial product {hi,lo} with multiplier in lo;
    // DIV partial remainder in hi, dividend shifting out / quotient in of lo.
    logic [WIDTH-1:0] p_hi_q, p_hi_d;
    logic [WIDTH-1:0] p_lo_q, p_lo_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH-1:0] res_lo_q, res_lo_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;

    // -------------------------------------------------------------------------
    // Single-cycle result path, computed straight from the ports so the result
    // is ready on the same edge that accepts start.
    // -------------------------------------------------------------------------
    logic [WIDTH:0]   add_w, sub_w;
    logic [WIDTH-1:0] imm_lo, imm_hi;
    logic             imm_carry, imm_ovf, imm_err, imm_zero;
    logic             needs_run;

    assign add_w = {1'b0, a} + {1'b0, b};
    assign sub_w = {1'b0, a} - {1'b0, b};

`ifdef CALC_DIV_EN
    assign needs_run = ((op_e'(op) == OP_MUL) || (op_e'(op) == OP_DIV)) && (b != '0);
`else
    assign needs_run = (op_e'(op) == OP_MUL) && (b != '0);
`endif

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        imm_lo    = '0;
        imm_hi    = '0;
        imm_carry = 1'b0;
        imm_ovf   = 1'b0;
        imm_err   = 1'b0;
        case (op_e'(op))
            OP_ADD: begin
                imm_lo    = add_w[WIDTH-1:0];
                imm_carry = add_w[WIDTH];
                // Same-sign operands producing an opposite-sign sum.
                imm_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                imm_lo    = sub_w[WIDTH-1:0];
                imm_carry = sub_w[WIDTH];   // borrow == (a < b)
                imm_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: imm_lo = a & b;
            OP_OR:  imm_lo = a | b;
            OP_XOR: imm_lo = a ^ b;
            OP_MUL: imm_lo = '0;            // only reached with b == 0
`ifdef CALC_DIV_EN
            OP_DIV: begin                   // only reached with b == 0
                imm_lo  = '1;
                imm_hi  = a;
                imm_err = 1'b1;
            end
`else
            OP_DIV: imm_err = 1'b1;
`endif
            OP_CMP: imm_lo = {{(WIDTH-3){1'b0}}, (a > b), (a == b), (a < b)};
        endcase
    end

    assign imm_zero = ((imm_hi | imm_lo) == '0);

    // -------------------------------------------------------------------------
    // One iteration of the multi-cycle datapath.
    // -------------------------------------------------------------------------
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi, mul_lo;
    logic [WIDTH-1:0] step_hi, step_lo;

    // Shift-add: add b into the upper half when the multiplier LSB is set, then
    // shift the whole {carry, hi, lo} right by one.
    assign mul_sum = {1'b0, p_hi_q} + (p_lo_q[0] ? {1'b0, b_q} : '0);
    assign mul_hi  = mul_sum[WIDTH:1];
    assign mul_lo  = {mul_sum[0], p_lo_q[WIDTH-1:1]};

`ifdef CALC_DIV_EN
    logic [WIDTH:0]   div_shift, div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] div_hi, div_lo;

    // Restoring step: bring the next dividend bit into the remainder; keep the
    // difference only if it did not go negative.
    assign div_shift = {p_hi_q, p_lo_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, b_q};
    assign div_ge    = (div_shift >= {1'b0, b_q});
    assign div_hi    = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign div_lo    = {p_lo_q[WIDTH-2:0], div_ge};
`endif

    always_comb begin
        step_hi = mul_hi;
        step_lo = mul_lo;
        case (op_q)
`ifdef CALC_DIV_EN
            OP_DIV: begin
                step_hi = div_hi;
                step_lo = div_lo;
            end
`endif
            default: begin
                step_hi = mul_hi;
                step_lo = mul_lo;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Next-state / next-register logic.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        b_d      = b_q;
        p_hi_d   = p_hi_q;
        p_lo_d   = p_lo_q;
        cnt_d    = cnt_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        err_d    = err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d   = op_e'(op);
                    b_d    = b;
                    p_hi_d = '0;
                    p_lo_d = a;
                    if (needs_run) begin
                        state_d = S_RUN;
                        cnt_d   = CW'(WIDTH);
                    end else begin
                        state_d  = S_DONE;
                        res_lo_d = imm_lo;
                        res_hi_d = imm_hi;
                        carry_d  = imm_carry;
                        ovf_d    = imm_ovf;
                        zero_d   = imm_zero;
                        err_d    = imm_err;
                    end
                end
            end
            S_RUN: begin
                p_hi_d = step_hi;
                p_lo_d = step_lo;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d  = S_DONE;
                    res_lo_d = step_lo;
                    res_hi_d = step_hi;
                    carry_d  = 1'b0;
                    ovf_d    = 1'b0;
                    zero_d   = ((step_hi | step_lo) == '0);
                    err_d    = 1'b0;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: every register, including the operand/iteration datapath, is reset
    // so an aborted operation leaves no stale state behind.
    // NOTE: sequential state uses non-blocking assignments so all flops sample
    // their _d values from the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= OP_ADD;
            b_q      <= '0;
            p_hi_q   <= '0;
            p_lo_q   <= '0;
            cnt_q    <= '0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            b_q      <= b_d;
            p_hi_q   <= p_hi_d;
            p_lo_q   <= p_lo_d;
            cnt_q    <= cnt_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign result_lo = res_lo_q;
    assign result_hi = res_hi_q;
    assign carry     = carry_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign err       = err_q;

endmodule

// File: tb/tb_calc_seq_alu.sv
// -----------------------------------------------------------------------------
// tb_calc_seq_alu -- self-checking bench for calc_seq_alu (WIDTH=8 and 16).
// A behavioural model computes each operation's expected result and latency;
// a single negedge compare process checks busy/done/results on every cycle.
// -----------------------------------------------------------------------------
module tb_calc_seq_alu;

    typedef struct packed {
        logic [15:0] lo;
        logic [15:0] hi;
        logic        carry;
        logic        ovf;
        logic        zero;
        logic        err;
        int          lat;
        int          start_cyc;
    } item_t;

    localparam bit [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                         XOR_ = 3'd4, MUL = 3'd5, DIV = 3'd6, CMP = 3'd7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       s8 = 1'b0;
    logic [2:0] op8 = '0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, carry8, ovf8, zero8, err8;
    logic [7:0] lo8, hi8;

    logic        s16 = 1'b0;
    logic [2:0]  op16 = '0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16, carry16, ovf16, zero16, err16;
    logic [15:0] lo16, hi16;

    calc_seq_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(s8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result_lo(lo8), .result_hi(hi8),
        .carry(carry8), .ovf(ovf8), .zero(zero8), .err(err8)
    );

    calc_seq_alu #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(s16), .op(op16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .result_lo(lo16), .result_hi(hi16),
        .carry(carry16), .ovf(ovf16), .zero(zero16), .err(err16)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;

    item_t q8[$];
    item_t q16[$];
    item_t held[2];

    logic        o_busy[2], o_done[2], o_carry[2], o_ovf[2], o_zero[2], o_err[2];
    logic [15:0] o_lo[2], o_hi[2];

    always_comb begin
        o_busy[0] = busy8;   o_busy[1] = busy16;
        o_done[0] = done8;   o_done[1] = done16;
        o_carry[0] = carry8; o_carry[1] = carry16;
        o_ovf[0] = ovf8;     o_ovf[1] = ovf16;
        o_zero[0] = zero8;   o_zero[1] = zero16;
        o_err[0] = err8;     o_err[1] = err16;
        o_lo[0] = {8'h00, lo8}; o_lo[1] = lo16;
        o_hi[0] = {8'h00, hi8}; o_hi[1] = hi16;
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: plain integer arithmetic on the opcode rules.
    function automatic item_t model(input int w, input bit [2:0] op,
                                    input longint a, input longint b);
        item_t  r;
        longint mask, half, ua, ub, sa, sb, s, r_lo, r_hi;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua = a & mask;
        ub = b & mask;
        sa = (ua >= half) ? ua - (mask + 1) : ua;
        sb = (ub >= half) ? ub - (mask + 1) : ub;
        r = '0;
        r.lat = 1;
        r_lo = 0;
        r_hi = 0;
        case (op)
            ADD: begin
                s = ua + ub;
                r_lo = s & mask;
                r.carry = (s > mask);
                r.ovf = (sa + sb > half - 1) || (sa + sb < -half);
            end
            SUB: begin
                r_lo = (ua - ub) & mask;
                r.carry = (ua < ub);
                r.ovf = (sa - sb > half - 1) || (sa - sb < -half);
            end
            AND_: r_lo = ua & ub;
            OR_:  r_lo = ua | ub;
            XOR_: r_lo = ua ^ ub;
            MUL: begin
                s = ua * ub;
                r_lo = s & mask;
                r_hi = s >> w;
                if (ub != 0) r.lat = w + 1;
            end
            DIV: begin
`ifdef CALC_DIV_EN
                if (ub != 0) begin
                    r_lo = ua / ub;
                    r_hi = ua % ub;
                    r.lat = w + 1;
                end else begin
                    r_lo = mask;
                    r_hi = ua;
                    r.err = 1'b1;
                end
`else
                r.err = 1'b1;
`endif
            end
            default: r_lo = ((ua < ub) ? 1 : 0) + ((ua == ub) ? 2 : 0) + ((ua > ub) ? 4 : 0);
        endcase
        r.lo = 16'(r_lo);
        r.hi = 16'(r_hi);
        r.zero = (r_lo == 0) && (r_hi == 0);
        return r;
    endfunction

    function automatic int q_size(input int d);
        return (d == 0) ? q8.size() : q16.size();
    endfunction

    task automatic cmp_fields(input int d, input item_t e);
        string p;
        p = (d == 0) ? "w8" : "w16";
        check({p, " result_lo"}, o_lo[d], e.lo);
        check({p, " result_hi"}, o_hi[d], e.hi);
        check({p, " carry"}, o_carry[d], e.carry);
        check({p, " ovf"}, o_ovf[d], e.ovf);
        check({p, " zero"}, o_zero[d], e.zero);
        check({p, " err"}, o_err[d], e.err);
    endtask

    task automatic mon_one(input int d);
        item_t head;
        bit    active;
        string p;
        p = (d == 0) ? "w8" : "w16";
        if (!rst_n) begin
            check({p, " reset busy"}, o_busy[d], 0);
            check({p, " reset done"}, o_done[d], 0);
            held[d] = '0;
            cmp_fields(d, held[d]);
            if (d == 0) q8.delete(); else q16.delete();
            return;
        end
        head = '0;
        if (q_size(d) > 0) head = (d == 0) ? q8[0] : q16[0];
        active = (q_size(d) > 0) && (cyc > head.start_cyc);
        check({p, " busy"}, o_busy[d], active);
        if (active && (cyc - head.start_cyc == head.lat)) begin
            check({p, " done"}, o_done[d], 1);
            cmp_fields(d, head);
            held[d] = head;
            if (d == 0) void'(q8.pop_front()); else void'(q16.pop_front());
        end else begin
            check({p, " done"}, o_done[d], 0);
            cmp_fields(d, held[d]);
        end
    endtask

    // Single compare process for both instances.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) mon_one(d);
    end

    task automatic scramble(input int d);
        if (d == 0) begin
            op8 = 3'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
        end else begin
            op16 = 3'($urandom); a16 = 16'($urandom); b16 = 16'($urandom);
        end
    endtask

    task automatic issue(input int d, input bit [2:0] op, input longint a, input longint b);
        item_t e;
        @(posedge clk);
        #1;
        e = model((d == 0) ? 8 : 16, op, a, b);
        e.start_cyc = cyc;
        if (d == 0) begin
            s8 = 1'b1; op8 = op; a8 = 8'(a); b8 = 8'(b);
            q8.push_back(e);
        end else begin
            s16 = 1'b1; op16 = op; a16 = 16'(a); b16 = 16'(b);
            q16.push_back(e);
        end
        @(posedge clk);
        #1;
        if (d == 0) s8 = 1'b0; else s16 = 1'b0;
        scramble(d);
    endtask

    // Hold start high for n edges while the DUT is busy; it must be ignored.
    task automatic pulse_ignored(input int d, input int n);
        scramble(d);
        if (d == 0) s8 = 1'b1; else s16 = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        if (d == 0) s8 = 1'b0; else s16 = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        int n;
        n = 0;
        while (q_size(d) != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check((d == 0) ? "w8 drain" : "w16 drain", q_size(d), 0);
    endtask

    function automatic longint pick(input int w);
        longint mask;
        mask = (longint'(1) << w) - 1;
        case ($urandom_range(0, 5))
            0: return 0;
            1: return 1;
            2: return mask;
            3: return longint'(1) << (w - 1);
            4: return (longint'(1) << (w - 1)) - 1;
            default: return longint'($urandom) & mask;
        endcase
    endfunction

    initial begin
        item_t r;
        held[0] = '0;
        held[1] = '0;

        // Hand-computed expectations pinning the model.
        r = model(8, ADD, 200, 100);
        check("pin add lo", r.lo, 44);   check("pin add carry", r.carry, 1);
        check("pin add ovf", r.ovf, 0);  check("pin add lat", r.lat, 1);
        r = model(8, SUB, 5, 7);
        check("pin sub lo", r.lo, 254);  check("pin sub carry", r.carry, 1);
        r = model(8, SUB, 8'h80, 1);
        check("pin sub2 lo", r.lo, 8'h7F); check("pin sub2 ovf", r.ovf, 1);
        r = model(8, MUL, 255, 255);
        check("pin mul hi", r.hi, 8'hFE); check("pin mul lo", r.lo, 8'h01);
        check("pin mul lat", r.lat, 9);
        r = model(8, MUL, 13, 11);
        check("pin mul13 lo", r.lo, 143);
        r = model(8, CMP, 9, 9);
        check("pin cmp lo", r.lo, 2);
        r = model(8, XOR_, 8'h5A, 8'h5A);
        check("pin xor zero", r.zero, 1);
        r = model(16, MUL, 16'hFFFF, 2);
        check("pin mul16 hi", r.hi, 1); check("pin mul16 lo", r.lo, 16'hFFFE);
        check("pin mul16 lat", r.lat, 17);
`ifdef CALC_DIV_EN
        r = model(8, DIV, 200, 7);
        check("pin div lo", r.lo, 28); check("pin div hi", r.hi, 4);
        check("pin div lat", r.lat, 9);
        r = model(8, DIV, 200, 0);
        check("pin div0 lo", r.lo, 8'hFF); check("pin div0 hi", r.hi, 200);
        check("pin div0 err", r.err, 1);
`else
        r = model(8, DIV, 200, 0);
        check("pin div off lo", r.lo, 0); check("pin div off zero", r.zero, 1);
        check("pin div off err", r.err, 1);
`endif

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed cases.
        issue(0, ADD, 200, 100);    wait_idle(0);
        issue(0, SUB, 5, 7);        wait_idle(0);
        issue(0, SUB, 8'h80, 1);    wait_idle(0);

        issue(0, MUL, 255, 255);
        @(posedge clk); #1;
        pulse_ignored(0, 1);        // captured on edge 3
        repeat (5) @(posedge clk);
        #1;
        pulse_ignored(0, 2);        // captured on edge 9 (RUN) and 10 (DONE)
        wait_idle(0);

        issue(0, DIV, 200, 7);      wait_idle(0);
        issue(0, DIV, 200, 0);      wait_idle(0);
        issue(0, CMP, 9, 9);        wait_idle(0);
        issue(0, XOR_, 8'h5A, 8'h5A); wait_idle(0);

        // Abort a MUL in its fourth RUN cycle.
        issue(0, MUL, 13, 11);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(0, ADD, 1, 1);        wait_idle(0);

        issue(1, MUL, 16'hFFFF, 2); wait_idle(1);

        // Randomized traffic on both widths.
        for (int i = 0; i < 150; i++) begin
            issue(0, 3'($urandom_range(0, 7)), pick(8), pick(8));
            if ($urandom_range(0, 2) == 0) pulse_ignored(0, 1);
            wait_idle(0);
        end
        for (int i = 0; i < 40; i++) begin
            issue(1, 3'($urandom_range(0, 7)), pick(16), pick(16));
            if ($urandom_range(0, 2) == 0) pulse_ignored(1, 1);
            wait_idle(1);
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/calc_seq_alu.md
Name: calc_seq_alu

Overview:
Parametrised, multi-cycle successor to the 8-bit combinational adder calculator. It accepts two WIDTH-bit unsigned operands and a 3-bit opcode under a start/done handshake. Logic ops complete in one cycle; multiply (shift-add) and divide (restoring) iterate one bit per cycle. It sits between the tile's input pins and output mux and drives result and flag registers held stable until the next operation completes.

Parameters:
WIDTH, 8, operand width in bits (legal 4..16); sets result width and iteration count.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
op  input  3  opcode, latched with start
a  input  WIDTH  operand A, latched with start
b  input  WIDTH  operand B, latched with start
busy  output  1  high while state != IDLE
done  output  1  one-cycle pulse when results update
result_lo  output  WIDTH  low result word
result_hi  output  WIDTH  high result word (MUL upper half, DIV remainder, else 0)
carry  output  1  ADD carry-out / SUB borrow
ovf  output  1  signed overflow for ADD/SUB, else 0
zero  output  1  {result_hi,result_lo} == 0
err  output  1  divide-by-zero or disabled op

Behaviour:
- Reset (async assert, sync-safe deassert): state IDLE; busy, done, result_lo, result_hi, carry, ovf, zero, err all 0; internal operand/iteration registers 0.
- States: IDLE, RUN, DONE.
- IDLE + start=1: latch a, b, op. MUL/DIV with b!=0 -> RUN, counter = WIDTH. All other cases -> DONE.
- RUN: one iteration per cycle, counter decrements; at counter==1 -> DONE. MUL and DIV spend exactly WIDTH cycles in RUN.
- DONE: result/flag registers update on entry; done=1 for exactly that one cycle; next state IDLE.
- Latency, start sampled at edge k: single-cycle ops -> done high after edge k+1; MUL/DIV -> done high after edge k+WIDTH+1. busy high from edge k+1 through the done cycle inclusive.
- start while busy, including the DONE cycle, is ignored; no queuing. Operand or op changes after latching have no effect.
- Results hold until the next DONE; flags update together with the results.
- Opcodes:
  - 000 ADD: lo = a+b mod 2^W; carry = bit W.
  - 001 SUB: lo = a-b mod 2^W; carry = (a<b).
  - 010 AND, 011 OR, 100 XOR: bitwise into lo.
  - 101 MUL: {hi,lo} = a*b, full 2W-bit result.
  - 110 DIV: lo = a/b, hi = a%b. If b==0: no RUN, err=1, lo = all ones, hi = a.
  - 111 CMP: lo[0] = (a<b), lo[1] = (a==b), lo[2] = (a>b), other bits 0.
- ovf = signed overflow (two's complement interpretation) for ADD/SUB; 0 for all other ops.
- carry = 0 for non-ADD/SUB ops. err = 0 except as stated above.
- hi = 0 for all ops except MUL and DIV.
- Reset asserted mid-RUN aborts the operation immediately; no done pulse is produced.

Optional Feature:
CALC_DIV_EN: when defined, the restoring divider is built and opcode 110 behaves as specified above. When undefined, there is no divider logic; opcode 110 takes the single-cycle path with lo=0, hi=0, err=1, zero=1, done one cycle after start. MUL is unaffected either way.

Test Plan:
- WIDTH=8, ADD a=200 b=100 -> lo=44, carry=1, ovf=0, zero=0; done exactly 1 cycle after start; busy high 1 cycle.
- SUB a=5 b=7 -> lo=254, carry=1. SUB a=0x80 b=0x01 -> lo=0x7F, ovf=1.
- MUL a=255 b=255 -> hi=0xFE, lo=0x01; done exactly 9 cycles after start. Pulse start again at cycles 3 and 9 -> ignored; exactly one done.
- DIV a=200 b=7 -> lo=28, hi=4, err=0, latency 9. DIV a=200 b=0 -> lo=0xFF, hi=200, err=1, latency 1. With CALC_DIV_EN undefined -> lo=0, hi=0, err=1, zero=1.
- CMP a=9 b=9 -> lo=0x02. Then XOR a=0x5A b=0x5A -> lo=0, zero=1.
- Start MUL 13*11, assert rst_n=0 at RUN cycle 4 -> all outputs 0 immediately, no done. After release, ADD 1+1 -> lo=2 after 1 cycle. Repeat MUL with WIDTH=16 a=0xFFFF b=2 -> hi=1, lo=0xFFFE, latency 17.
